// File: rtl/exec_muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// exec_muldiv_seq_pkg
//
// Shared definitions for the sequential multiply/divide execution unit:
//   - `REG_SIZE / `REG_ADDR  : default datapath width and register-address width
//   - muldiv_op_e            : operation codes carried on the 2-bit op port
//   - muldiv_state_e         : FSM state encodings (IDLE, RUN, DONE)
//   - op_is_signed/op_is_div : small decode helpers used by the top and step
//
// Optional feature macro: MULDIV_DIV_EN (enables the divider datapath).
// -----------------------------------------------------------------------------
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

`ifndef REG_ADDR
`define REG_ADDR 5
`endif

package exec_muldiv_seq_pkg;

   typedef enum logic [1:0] {
      MULDIV_MULT  = 2'd0,
      MULDIV_MULTU = 2'd1,
      MULDIV_DIV   = 2'd2,
      MULDIV_DIVU  = 2'd3
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // Signed ops need operand magnitudes and a sign fix-up at the end.
   function automatic logic op_is_signed(input muldiv_op_e op);
      return (op == MULDIV_MULT) || (op == MULDIV_DIV);
   endfunction

   // Both divide codes have the upper op bit set.
   function automatic logic op_is_div(input muldiv_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/exec_muldiv_seq_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//
// Purely combinational single radix-2 iteration of the multiply/divide unit.
//   Multiply : shift-add. {acc_hi,acc_lo} holds {partial product, multiplier};
//              when the multiplier LSB is set the multiplicand is added into
//              the upper half, then the whole pair shifts right by one.
//   Divide   : restoring. acc_hi holds the partial remainder, acc_lo the
//              dividend being shifted out / quotient being shifted in.
//
// Ports:
//   is_div   in  select divide step (only present with MULDIV_DIV_EN)
//   acc_hi   in  upper accumulator (partial product / remainder)
//   acc_lo   in  lower accumulator (multiplier / dividend->quotient)
//   operand  in  multiplicand or divisor magnitude
//   next_hi  out updated upper accumulator
//   next_lo  out updated lower accumulator
//
// Optional feature macro: MULDIV_DIV_EN (without it only the multiply step
// exists).
// -----------------------------------------------------------------------------
module muldiv_step
   import exec_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = `REG_SIZE
)
(
`ifdef MULDIV_DIV_EN
   input  logic             is_div,
`endif
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] add_sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] rem_shift;
`endif

   // One iteration. The multiply carry out of the add becomes the new MSB of
   // the upper half, so no product bit is lost during the right shift. The
   // divide path compares the shifted remainder against the divisor and only
   // subtracts (and records a quotient 1) when it fits.
   always_comb begin
      add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
      next_hi = add_sum[WIDTH:1];
      next_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      rem_shift = {acc_hi, acc_lo[WIDTH-1]};
      if (is_div) begin
         if (rem_shift >= {1'b0, operand}) begin
            next_hi = rem_shift[WIDTH-1:0] - operand;
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            next_hi = rem_shift[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

endmodule

// File: rtl/exec_muldiv_seq.sv
// -----------------------------------------------------------------------------
// exec_muldiv_seq
//
// Sequential (one bit per cycle) multiply/divide unit for the execute stage.
// An accepted start latches the operation, operand magnitudes and signs, then
// runs WIDTH iterations of muldiv_step; the final iteration lands the
// sign-corrected result and pulses done/regwrite_out for one cycle.
//
// Ports:
//   clk           in  clock, everything on posedge
//   rst_n         in  synchronous active-low reset
//   start         in  operation request (honoured in IDLE and DONE)
//   op            in  0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   src1, src2    in  operands (multiplicand/multiplier or dividend/divisor)
//   wreg_in       in  destination register address
//   flush         in  pipeline kill, forces IDLE, wins over start
//   busy          out state != IDLE
//   stall         out state == RUN
//   done          out one-cycle completion pulse
//   illegal       out DIV/DIVU issued while the divider is compiled out
//   result_lo/hi  out product low/high or quotient/remainder, held until next
//                     completion
//   wreg_out      out destination of the completed operation
//   regwrite_out  out write-back enable for the completed operation
//
// Optional feature macro: MULDIV_DIV_EN. When undefined the divider is absent
// and a DIV/DIVU request completes in one edge flagged illegal with zero
// results and no write-back.
// -----------------------------------------------------------------------------
module exec_muldiv_seq
   import exec_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = `REG_SIZE
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     src1,
   input  logic [WIDTH-1:0]     src2,
   input  logic [`REG_ADDR-1:0] wreg_in,
   input  logic                 flush,
   output logic                 busy,
   output logic                 stall,
   output logic                 done,
   output logic                 illegal,
   output logic [WIDTH-1:0]     result_lo,
   output logic [WIDTH-1:0]     result_hi,
   output logic [`REG_ADDR-1:0] wreg_out,
   output logic                 regwrite_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   muldiv_state_e        state;
   muldiv_op_e           op_r;
   muldiv_op_e           op_in;
   logic                 sign_a;
   logic                 sign_b;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH-1:0]     acc_hi;
   logic [WIDTH-1:0]     acc_lo;
   logic [WIDTH-1:0]     step_hi;
   logic [WIDTH-1:0]     step_lo;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;
   logic [2*WIDTH-1:0]   prod_neg;
   logic [CNT_W-1:0]     cnt;
   logic [`REG_ADDR-1:0] wreg_r;
   logic                 launch;
   logic                 illegal_op;
   logic                 in_sign_a;
   logic                 in_sign_b;
   logic [WIDTH-1:0]     in_mag_a;
   logic [WIDTH-1:0]     in_mag_b;

   // Status flags come straight from the registered state.
   assign busy  = (state != ST_IDLE);
   assign stall = (state == ST_RUN);

   // A new request is accepted whenever no iteration is in flight; start
   // during RUN is simply not looked at.
   assign op_in  = muldiv_op_e'(op);
   assign launch = start && (state != ST_RUN);

   // Signed ops iterate on magnitudes; the signs are remembered for the
   // fix-up. Negating the most-negative value gives the same bit pattern,
   // which is exactly its unsigned magnitude.
   assign in_sign_a = op_is_signed(op_in) & src1[WIDTH-1];
   assign in_sign_b = op_is_signed(op_in) & src2[WIDTH-1];
   assign in_mag_a  = in_sign_a ? -src1 : src1;
   assign in_mag_b  = in_sign_b ? -src2 : src2;

`ifdef MULDIV_DIV_EN
   assign illegal_op = 1'b0;
`else
   assign illegal_op = op_is_div(op_in);
`endif

   muldiv_step #(
      .WIDTH   (WIDTH)
   ) u_step (
`ifdef MULDIV_DIV_EN
      .is_div  (op_is_div(op_r)),
`endif
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (mag_b),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Sign fix-up applied to the output of the final iteration. A signed
   // product is negated as one double-width value. For signed divide the
   // quotient takes the XOR of the signs and the remainder the dividend sign;
   // divide by zero returns all ones and the original dividend instead.
   // Most-negative / -1 needs no special case: the magnitude quotient is
   // 2^(WIDTH-1), whose negation is the same pattern, with zero remainder.
   always_comb begin
      fix_hi   = step_hi;
      fix_lo   = step_lo;
      prod_neg = -{step_hi, step_lo};
      case (op_r)
         MULDIV_MULT: begin
            if (sign_a ^ sign_b) begin
               {fix_hi, fix_lo} = prod_neg;
            end
         end
`ifdef MULDIV_DIV_EN
         MULDIV_DIV: begin
            fix_hi = sign_a ? -step_hi : step_hi;
            if (mag_b == '0) begin
               fix_lo = '1;
            end else begin
               fix_lo = (sign_a ^ sign_b) ? -step_lo : step_lo;
            end
         end
`endif
         default: begin
         end
      endcase
   end

   // Control FSM and datapath registers. Reset beats flush, flush beats any
   // start, and an accepted start either begins iterating or, for a divide
   // with the divider compiled out, completes immediately as illegal. The
   // edge that performs iteration WIDTH loads the results and raises done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op_r         <= MULDIV_MULT;
         sign_a       <= 1'b0;
         sign_b       <= 1'b0;
         mag_b        <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         cnt          <= '0;
         wreg_r       <= '0;
         done         <= 1'b0;
         illegal      <= 1'b0;
         regwrite_out <= 1'b0;
         result_lo    <= '0;
         result_hi    <= '0;
         wreg_out     <= '0;
      end else begin
         done         <= 1'b0;
         illegal      <= 1'b0;
         regwrite_out <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
         end else if (launch) begin
            op_r   <= op_in;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            mag_b  <= in_mag_b;
            acc_hi <= '0;
            acc_lo <= in_mag_a;
            cnt    <= '0;
            wreg_r <= wreg_in;
            if (illegal_op) begin
               state     <= ST_DONE;
               done      <= 1'b1;
               illegal   <= 1'b1;
               result_lo <= '0;
               result_hi <= '0;
               wreg_out  <= wreg_in;
            end else begin
               state <= ST_RUN;
            end
         end else if (state == ST_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state        <= ST_DONE;
               done         <= 1'b1;
               regwrite_out <= 1'b1;
               result_lo    <= fix_lo;
               result_hi    <= fix_hi;
               wreg_out     <= wreg_r;
            end
         end else begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_exec_muldiv_seq
//
// Directed self-checking bench for exec_muldiv_seq. Inputs change on the
// falling edge and outputs are sampled on the falling edge, so every check
// sits half a cycle away from the active rising edge. Divide vectors are
// exercised when MULDIV_DIV_EN is defined; otherwise the illegal-divide path
// is checked instead.
// -----------------------------------------------------------------------------
module tb_exec_muldiv_seq;

   localparam int WIDTH = 32;

   localparam int INJ_NONE  = 0;
   localparam int INJ_START = 1;
   localparam int INJ_FLUSH = 2;
   localparam int INJ_RESET = 3;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [4:0]       wreg_in;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic             illegal;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [4:0]       wreg_out;
   logic             regwrite_out;

   int checks   = 0;
   int failures = 0;

   int   lat;
   int   stalls;
   logic inj_busy;

   exec_muldiv_seq #(
      .WIDTH        (WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .src1         (src1),
      .src2         (src2),
      .wreg_in      (wreg_in),
      .flush        (flush),
      .busy         (busy),
      .stall        (stall),
      .done         (done),
      .illegal      (illegal),
      .result_lo    (result_lo),
      .result_hi    (result_hi),
      .wreg_out     (wreg_out),
      .regwrite_out (regwrite_out)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request at the current falling edge, then watches up to
   // WIDTH+8 cycles for done. Cycle i is sampled just after rising edge i,
   // edge 0 being the one that accepts the request. An optional disturbance
   // (extra start, flush or reset) is driven so the DUT samples it at edge
   // inj_at. Returns with the bench at the falling edge of the done cycle,
   // or lat = -1 if done never appeared.
   task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [4:0] w, input int inj_kind, input int inj_at,
                                output int lat_o, output int stalls_o, output logic inj_busy_o);
      start   = 1'b1;
      op      = o;
      src1    = a;
      src2    = b;
      wreg_in = w;
      lat_o      = -1;
      stalls_o   = 0;
      inj_busy_o = 1'b0;
      for (int i = 0; i < WIDTH + 8; i++) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         rst_n = 1'b1;
         if (i == inj_at) inj_busy_o = busy;
         if (done) begin
            lat_o = i;
            break;
         end
         stalls_o = stalls_o + (stall ? 1 : 0);
         if (i == inj_at - 1) begin
            case (inj_kind)
               INJ_START: begin
                  start = 1'b1;
                  op    = OP_MULTU;
                  src1  = 32'd3;
                  src2  = 32'd3;
               end
               INJ_FLUSH: flush = 1'b1;
               INJ_RESET: rst_n = 1'b0;
               default: ;
            endcase
         end
      end
   endtask

   // Checks a normally completed operation in its done cycle.
   task automatic checkDone(input string tag, input logic [WIDTH-1:0] exp_lo, input logic [WIDTH-1:0] exp_hi,
                            input logic [4:0] exp_w);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(WIDTH));
      checkOutput({tag, "_stall_cycles"}, 64'(stalls), 64'(WIDTH));
      checkOutput({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
      checkOutput({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
      checkOutput({tag, "_wreg"}, 64'(wreg_out), 64'(exp_w));
      checkOutput({tag, "_flags"}, {60'd0, regwrite_out, illegal, stall, busy}, 64'b1001);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      flush   = 1'b0;
      op      = OP_MULT;
      src1    = '0;
      src2    = '0;
      wreg_in = '0;
      idle(2);

      // Reset state: everything zero.
      checkOutput("reset_ctrl", {59'd0, busy, stall, done, illegal, regwrite_out}, 64'd0);
      checkOutput("reset_results", {result_hi, result_lo}, 64'd0);
      checkOutput("reset_wreg", 64'(wreg_out), 64'd0);
      rst_n = 1'b1;
      idle(1);

      // MULTU 7*6
      applyStimulus(OP_MULTU, 32'd7, 32'd6, 5'd3, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("multu_7x6", 32'd42, 32'd0, 5'd3);
      idle(1);
      checkOutput("done_one_cycle", {62'd0, done, regwrite_out}, 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("hold_lo", 64'(result_lo), 64'd42);

      // MULT -5*3
      applyStimulus(OP_MULT, 32'hFFFF_FFFB, 32'd3, 5'd4, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("mult_m5x3", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 5'd4);
      idle(1);

      // MULTU max*max
      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("multu_max", 32'h0000_0001, 32'hFFFF_FFFE, 5'd5);
      idle(1);

      // MULT most-negative * 2 = -2^32
      applyStimulus(OP_MULT, 32'h8000_0000, 32'd2, 5'd6, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("mult_minx2", 32'h0000_0000, 32'hFFFF_FFFF, 5'd6);
      idle(1);

      // Start during RUN at edge 5 is ignored: 1234*5678 = 0x6AE9BC
      applyStimulus(OP_MULTU, 32'd1234, 32'd5678, 5'd7, INJ_START, 5, lat, stalls, inj_busy);
      checkDone("start_in_run", 32'h006A_E9BC, 32'd0, 5'd7);
      idle(1);

      // Flush at edge 10: no done, previous results kept
      applyStimulus(OP_MULT, 32'd9, 32'd9, 5'd20, INJ_FLUSH, 10, lat, stalls, inj_busy);
      checkOutput("flush_no_done", 64'(lat), 64'(-1));
      checkOutput("flush_busy_edge10", 64'(inj_busy), 64'd0);
      checkOutput("flush_results_kept", {result_hi, result_lo}, 64'h0000_0000_006A_E9BC);
      checkOutput("flush_wreg_kept", 64'(wreg_out), 64'd7);
      idle(1);

      // Back-to-back: second request issued in the DONE cycle
      applyStimulus(OP_MULTU, 32'd100, 32'd200, 5'd8, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("b2b_first", 32'd20000, 32'd0, 5'd8);
      applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'h4000_0000, 5'd9, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("b2b_second", 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
      idle(1);

`ifdef MULDIV_DIV_EN
      applyStimulus(OP_DIV, 32'd100, 32'd7, 5'd10, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("div_100_7", 32'd14, 32'd2, 5'd10);
      idle(1);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd11, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'd11);
      idle(1);
      applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd12, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("divu_by0", 32'hFFFF_FFFF, 32'd5, 5'd12);
      idle(1);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd13, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("div_m7_by0", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5'd13);
      idle(1);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("div_overflow", 32'h8000_0000, 32'd0, 5'd14);
      idle(1);
      applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd15, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("divu_max_16", 32'h0FFF_FFFF, 32'd15, 5'd15);
      idle(1);
`else
      // Divider compiled out: DIV completes next cycle as illegal
      applyStimulus(OP_DIV, 32'd100, 32'd7, 5'd10, INJ_NONE, -1, lat, stalls, inj_busy);
      checkOutput("illegal_div_latency", 64'(lat), 64'd0);
      checkOutput("illegal_div_flags", {60'd0, done, illegal, regwrite_out, stall}, 64'b1100);
      checkOutput("illegal_div_results", {result_hi, result_lo}, 64'd0);
      idle(1);
      checkOutput("illegal_clears", {61'd0, done, illegal, busy}, 64'd0);
      applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd11, INJ_NONE, -1, lat, stalls, inj_busy);
      checkOutput("illegal_divu_latency", 64'(lat), 64'd0);
      checkOutput("illegal_divu_flags", {60'd0, done, illegal, regwrite_out, stall}, 64'b1100);
      idle(1);
`endif

      // Reset mid-RUN at edge 10: everything cleared, no done
      applyStimulus(OP_MULTU, 32'd7, 32'd6, 5'd17, INJ_RESET, 10, lat, stalls, inj_busy);
      checkOutput("reset_run_no_done", 64'(lat), 64'(-1));
      checkOutput("reset_run_busy", 64'(inj_busy), 64'd0);
      checkOutput("reset_run_results", {result_hi, result_lo}, 64'd0);
      checkOutput("reset_run_outs", {57'd0, wreg_out, done, regwrite_out}, 64'd0);

      // Recovery after reset
      applyStimulus(OP_MULTU, 32'd7, 32'd6, 5'd18, INJ_NONE, -1, lat, stalls, inj_busy);
      checkDone("after_reset", 32'd42, 32'd0, 5'd18);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_muldiv_seq.md
EXEC_MULDIV_SEQ -- requirements
Module: exec_muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default `REG_SIZE (32), operand/result width.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on posedge clk.
REQ-003 The block SHALL have input rst_n, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have inputs start (1, request), op (2; 0 MULT, 1 MULTU, 2 DIV, 3 DIVU), src1/src2 (WIDTH, operands), wreg_in (`REG_ADDR, destination), flush (1, pipeline kill).
REQ-005 The block SHALL have outputs busy (1), stall (1), done (1), illegal (1), result_lo/result_hi (WIDTH each), wreg_out (`REG_ADDR), regwrite_out (1).

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DONE; encoding free.
REQ-007 IDLE: start=1 and flush=0 at an edge SHALL latch op, operand magnitudes, operand signs, wreg_in, clear iteration count, and go to RUN.
REQ-008 RUN: each edge SHALL perform one radix-2 step (shift-add for MULT/MULTU, restoring subtract for DIV/DIVU) and increment count; the edge completing step WIDTH SHALL go to DONE.
REQ-009 Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH (32 for default), for all ops.
REQ-010 DONE: done=1 and regwrite_out=1 for exactly one cycle; result_lo/result_hi/wreg_out valid; next edge goes to IDLE, or to RUN if start=1 and flush=0 (back-to-back).
REQ-011 result_lo/result_hi/wreg_out SHALL hold their values until the next DONE; done/regwrite_out SHALL be 0 outside DONE.
REQ-012 busy SHALL equal (state != IDLE); stall SHALL equal (state == RUN), both decoded from registered state only.
REQ-013 start in RUN SHALL be ignored with no effect on the current operation.
REQ-014 flush=1 at any edge SHALL force IDLE; done and regwrite_out stay 0; result registers unchanged; flush wins over simultaneous start.
REQ-015 Multiply: {result_hi,result_lo} = 2*WIDTH-bit product; MULT signed (two's complement sign fix-up on DONE entry), MULTU unsigned.
REQ-016 Divide: result_lo = quotient truncated toward zero, result_hi = remainder with sign of dividend; DIVU unsigned.
REQ-017 Divide by zero SHALL give result_lo = all ones, result_hi = src1, normal latency, no error flag.
REQ-018 Signed overflow (most-negative / -1) SHALL give result_lo = most-negative value, result_hi = 0.

Reset
REQ-019 rst_n=0 at an edge SHALL force IDLE and clear done, illegal, regwrite_out, busy-related state, result_lo, result_hi, wreg_out to 0, overriding start and flush, including mid-RUN.
REQ-020 Operations in progress at reset SHALL be discarded; no done is produced for them.

Configuration
REQ-021 Macro MULDIV_DIV_EN defined: DIV/DIVU SHALL execute per REQ-016..018; illegal stays 0.
REQ-022 MULDIV_DIV_EN undefined: divider logic SHALL be absent; DIV/DIVU start goes IDLE->DONE in one edge with result_lo=result_hi=0, regwrite_out=0, illegal=1 for the DONE cycle.

Structure
REQ-023 Op codes (MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU) and state encodings SHALL live in define.v beside `REG_SIZE/`REG_ADDR.
REQ-024 One combinational sub-module muldiv_step SHALL compute a single iteration (partial product/remainder update) from current registers and op; FSM, counter and sign fix-up stay in exec_muldiv_seq.

Verification
REQ-025 MULTU 7*6 -> done at edge 32, result_lo=42, result_hi=0, stall high edges 1..31 window, wreg_out=wreg_in.
REQ-026 MULT -5*3 -> result_lo=0xFFFFFFF1, result_hi=0xFFFFFFFF; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-027 DIV 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-028 flush at edge 10 of a MULT -> IDLE at edge 10, no done, previous results unchanged; start during RUN at edge 5 -> ignored, original result delivered.
REQ-029 Back-to-back: start held high in DONE -> second operation done exactly WIDTH edges later; rst_n low mid-RUN -> all outputs 0 next cycle, no done.
REQ-030 Without MULDIV_DIV_EN: DIV start -> next cycle done=1, illegal=1, regwrite_out=0, results 0.
